vga_mirror_ram: RTL and testbench

//  Parametrised multi-channel mirror RAM feeding the VGA debug text renderer.
//  NUM_CH independent write channels (regfile, instr mem, data mem, ...) each update a ROWS x COLS word store.

---
 rtl/vga_mirror_ram.sv | 149 ++++++++++++++
 tb/tb_vga_mirror_ram.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_mirror_ram.sv
// Multi-channel mirror RAM for the VGA debug text renderer: per-channel flat writes fold
// onto a ROWS x COLS store, a clear sweep zeroes it, and one registered port reads a row.
module vga_mirror_ram #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ROWS   = 46,
   parameter int unsigned COLS   = 2,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear_req_i,
   output logic                            busy_o,
   input  logic [NUM_CH-1:0]               wr_en_i,
   input  logic [NUM_CH*ADDR_W-1:0]        wr_addr_i,
   input  logic [NUM_CH*DATA_W-1:0]        wr_data_i,
   input  logic                            rd_en_i,
   input  logic [$clog2(ROWS)-1:0]         rd_row_i,
   output logic                            rd_valid_o,
   output logic [NUM_CH*COLS*DATA_W-1:0]   rd_data_o,
   output logic [NUM_CH-1:0]               oob_err_o,
   output logic [NUM_CH-1:0]               drop_err_o,
   input  logic                            err_clr_i
);

   localparam int unsigned RowW = $clog2(ROWS);
   localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RowW:0]   RowsL    = ROWS[RowW:0];
   localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);
   localparam logic [0:0]      StIdle   = 1'b0;
   localparam logic [0:0]      StClear  = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [RowW-1:0]        row_q, row_d;
   logic [DATA_W-1:0]      mem_q [NUM_CH][COLS][ROWS];
   logic [NUM_CH-1:0]      in_rng;
   logic [ColW-1:0]        wr_col [NUM_CH];
   logic [RowW-1:0]        wr_row [NUM_CH];
   logic [NUM_CH-1:0]      wr_ok, set_oob, set_drop;
   logic [NUM_CH-1:0]      oob_q, drop_q;
   logic                   rd_valid_q;
   logic [NUM_CH*COLS*DATA_W-1:0] rd_word, rd_data_q;

   assign busy_o = (state_q == StClear);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      if (state_q == StClear) begin
         if (row_q == LastRow) begin
            state_d = StIdle;
            row_d   = '0;
         end else begin
            row_d = row_q + 1'b1;
         end
      end else if (clear_req_i) begin
         state_d = StClear;
         row_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StClear;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // Fold flat address onto (col,row) with one range compare per column instead of a divider.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         in_rng[ch] = 1'b0;
         wr_col[ch] = '0;
         wr_row[ch] = '0;
         for (int c = 0; c < COLS; c++) begin
            if (!in_rng[ch] && (wr_addr_i[ch*ADDR_W +: ADDR_W] < ADDR_W'((c + 1) * ROWS))) begin
               in_rng[ch] = 1'b1;
               wr_col[ch] = ColW'(c);
               wr_row[ch] = RowW'(wr_addr_i[ch*ADDR_W +: ADDR_W] - ADDR_W'(c * ROWS));
            end
         end
      end
      wr_ok    = wr_en_i & {NUM_CH{~busy_o}} & in_rng;
      set_oob  = wr_en_i & {NUM_CH{~busy_o}} & ~in_rng;
      set_drop = wr_en_i & {NUM_CH{busy_o}};
   end

   // Storage is deliberately not reset; the sweep zeroes it one row per cycle.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int c = 0; c < COLS; c++) begin
               mem_q[ch][c][row_q] <= '0;
            end
         end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (wr_ok[ch]) begin
            mem_q[ch][wr_col[ch]][wr_row[ch]] <= wr_data_i[ch*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if ({1'b0, rd_row_i} < RowsL) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int c = 0; c < COLS; c++) begin
               rd_word[((NUM_CH - 1 - ch) * COLS + c) * DATA_W +: DATA_W] =
                  mem_q[ch][c][rd_row_i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) begin
            rd_data_q <= rd_word;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oob_q  <= '0;
         drop_q <= '0;
      end else if (err_clr_i) begin
         oob_q  <= '0;
         drop_q <= '0;
      end else begin
         oob_q  <= oob_q | set_oob;
         drop_q <= drop_q | set_drop;
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign oob_err_o  = oob_q;
   assign drop_err_o = drop_q;

endmodule

// File: tb/tb_vga_mirror_ram.sv
// Directed bench for vga_mirror_ram: sweep timing, folding, flags, read ordering, reset.
module tb_vga_mirror_ram;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clear_req_i = 1'b0;
   logic         busy_o;
   logic [2:0]   wr_en_i = '0;
   logic [95:0]  wr_addr_i = '0;
   logic [95:0]  wr_data_i = '0;
   logic         rd_en_i = 1'b0;
   logic [5:0]   rd_row_i = '0;
   logic         rd_valid_o;
   logic [191:0] rd_data_o;
   logic [2:0]   oob_err_o;
   logic [2:0]   drop_err_o;
   logic         err_clr_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int n;
   logic [191:0] e;

   vga_mirror_ram dut (
      .clk         (clk),
      .rst         (rst),
      .clear_req_i (clear_req_i),
      .busy_o      (busy_o),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .rd_en_i     (rd_en_i),
      .rd_row_i    (rd_row_i),
      .rd_valid_o  (rd_valid_o),
      .rd_data_o   (rd_data_o),
      .oob_err_o   (oob_err_o),
      .drop_err_o  (drop_err_o),
      .err_clr_i   (err_clr_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected-row builder: ch0 is the most significant channel, col0 its low word.
   function automatic logic [191:0] put(input logic [191:0] v, input int ch, input int col,
                                         input logic [31:0] d);
      v[((2 - ch) * 2 + col) * 32 +: 32] = d;
      return v;
   endfunction

   task automatic wr(input int ch, input logic [31:0] a, input logic [31:0] d);
      wr_en_i = '0;
      wr_en_i[ch] = 1'b1;
      wr_addr_i[ch*32 +: 32] = a;
      wr_data_i[ch*32 +: 32] = d;
      @(negedge clk);
      wr_en_i = '0;
   endtask

   task automatic rd(input logic [5:0] row);
      rd_en_i  = 1'b1;
      rd_row_i = row;
      @(negedge clk);
      rd_en_i  = 1'b0;
      chk("rd_valid", {191'd0, rd_valid_o}, 192'd1);
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (busy_o && cnt < 200);
   endtask

   initial begin
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", {191'd0, busy_o}, 192'd1);
      chk("rst_valid", {191'd0, rd_valid_o}, 192'd0);
      chk("rst_data", rd_data_o, 192'd0);
      chk("rst_flags", {186'd0, oob_err_o, drop_err_o}, 192'd0);

      rst = 1'b0;
      wait_idle(n);
      chk("init_sweep_len", 192'(n), 192'd46);
      @(negedge clk);
      for (int r = 0; r < 46; r++) begin
         rd(6'(r));
         chk("init_row_zero", rd_data_o, 192'd0);
      end
      @(negedge clk);
      chk("valid_drops", {191'd0, rd_valid_o}, 192'd0);

      // Folding: 5 -> col0 row5, 51 -> col1 row5
      wr(1, 32'd5, 32'hDEADBEEF);
      wr(1, 32'd51, 32'h12345678);
      rd(6'd5);
      e = put(put(192'd0, 1, 0, 32'hDEADBEEF), 1, 1, 32'h12345678);
      chk("fold_row5", rd_data_o, e);
      @(negedge clk);
      chk("hold_data", rd_data_o, e);

      wr_en_i = 3'b111;
      wr_addr_i = '0;
      wr_data_i = {32'h3, 32'h2, 32'h1};
      @(negedge clk);
      wr_en_i = '0;
      rd(6'd0);
      chk("multi_ch_row0", rd_data_o,
          put(put(put(192'd0, 0, 0, 32'h1), 1, 0, 32'h2), 2, 0, 32'h3));

      wr(2, 32'd92, 32'hBAD0BAD0);
      chk("oob_set", {189'd0, oob_err_o}, 192'd4);
      chk("oob_no_drop", {189'd0, drop_err_o}, 192'd0);
      rd(6'd0);
      chk("oob_no_store", rd_data_o,
          put(put(put(192'd0, 0, 0, 32'h1), 1, 0, 32'h2), 2, 0, 32'h3));
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("oob_cleared", {189'd0, oob_err_o}, 192'd0);
      err_clr_i = 1'b1;
      wr(2, 32'd92, 32'hBAD0BAD0);
      err_clr_i = 1'b0;
      chk("clr_priority", {189'd0, oob_err_o}, 192'd0);
      wr(2, 32'd91, 32'h0000CAFE);
      rd(6'd45);
      chk("last_addr_row45", rd_data_o, put(192'd0, 2, 1, 32'h0000CAFE));

      // Sweep from IDLE: same-cycle write accepted, later write dropped, re-request ignored
      clear_req_i = 1'b1;
      wr(0, 32'd10, 32'h55);
      clear_req_i = 1'b0;
      chk("clear_busy", {191'd0, busy_o}, 192'd1);
      rd(6'd10);
      chk("read_during_clear", rd_data_o, put(192'd0, 0, 0, 32'h55));
      clear_req_i = 1'b1;
      wr(0, 32'd3, 32'h77);
      clear_req_i = 1'b0;
      chk("drop_set", {189'd0, drop_err_o}, 192'd1);
      wait_idle(n);
      chk("clear_sweep_len", 192'(n), 192'd44);
      @(negedge clk);
      for (int r = 0; r < 46; r++) begin
         rd(6'(r));
         chk("cleared_row_zero", rd_data_o, 192'd0);
      end

      // Read-before-write on the same row
      wr_en_i = 3'b001;
      wr_addr_i[31:0] = 32'd7;
      wr_data_i[31:0] = 32'hA;
      rd_en_i = 1'b1;
      rd_row_i = 6'd7;
      @(negedge clk);
      wr_en_i = '0;
      rd_en_i = 1'b0;
      chk("rbw_old", rd_data_o, 192'd0);
      rd(6'd7);
      chk("rbw_new", rd_data_o, put(192'd0, 0, 0, 32'hA));
      rd(6'd50);
      chk("row_oob_zero", rd_data_o, 192'd0);

      // Reset in the middle of a sweep
      rd(6'd7);
      clear_req_i = 1'b1;
      @(negedge clk);
      clear_req_i = 1'b0;
      wr(0, 32'd1, 32'h5);
      repeat (19) @(negedge clk);
      chk("drop_before_rst", {189'd0, drop_err_o}, 192'd1);
      chk("busy_before_rst", {191'd0, busy_o}, 192'd1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {191'd0, busy_o}, 192'd1);
      chk("midrst_data", rd_data_o, 192'd0);
      chk("midrst_flags", {186'd0, oob_err_o, drop_err_o}, 192'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_idle(n);
      chk("restart_sweep_len", 192'(n), 192'd46);
      chk("post_flags", {186'd0, oob_err_o, drop_err_o}, 192'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
